// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse keyer.
//   - symbol code constants (word space, highest accepted code)
//   - FSM state encoding
//   - pattern_t: element count plus dit/dah bits, first element in bits[4],
//     1 = dah, 0 = dit
package morse_pkg;

  localparam logic [5:0] SYM_WORD      = 6'd36;
  localparam logic [5:0] SYM_MAX_VALID = 6'd36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MARK,
    S_SPACE,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] bits;
  } pattern_t;

endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational symbol code -> Morse pattern lookup.
// Ports:
//   code  in   6-bit symbol (0-25 A-Z, 26-35 0-9)
//   pat   out  pattern_t, elements left-aligned (first element in bits[4]),
//              1 = dah. Word space and unused codes return len = 0.
import morse_pkg::*;

module morse_rom (
  input  logic [5:0] code,
  output pattern_t   pat
);

  always_comb begin
    pat = '0;
    case (code)
      6'd0:  pat = {3'd2, 5'b01000};  // A .-
      6'd1:  pat = {3'd4, 5'b10000};  // B -...
      6'd2:  pat = {3'd4, 5'b10100};  // C -.-.
      6'd3:  pat = {3'd3, 5'b10000};  // D -..
      6'd4:  pat = {3'd1, 5'b00000};  // E .
      6'd5:  pat = {3'd4, 5'b00100};  // F ..-.
      6'd6:  pat = {3'd3, 5'b11000};  // G --.
      6'd7:  pat = {3'd4, 5'b00000};  // H ....
      6'd8:  pat = {3'd2, 5'b00000};  // I ..
      6'd9:  pat = {3'd4, 5'b01110};  // J .---
      6'd10: pat = {3'd3, 5'b10100};  // K -.-
      6'd11: pat = {3'd4, 5'b01000};  // L .-..
      6'd12: pat = {3'd2, 5'b11000};  // M --
      6'd13: pat = {3'd2, 5'b10000};  // N -.
      6'd14: pat = {3'd3, 5'b11100};  // O ---
      6'd15: pat = {3'd4, 5'b01100};  // P .--.
      6'd16: pat = {3'd4, 5'b11010};  // Q --.-
      6'd17: pat = {3'd3, 5'b01000};  // R .-.
      6'd18: pat = {3'd3, 5'b00000};  // S ...
      6'd19: pat = {3'd1, 5'b10000};  // T -
      6'd20: pat = {3'd3, 5'b00100};  // U ..-
      6'd21: pat = {3'd4, 5'b00010};  // V ...-
      6'd22: pat = {3'd3, 5'b01100};  // W .--
      6'd23: pat = {3'd4, 5'b10010};  // X -..-
      6'd24: pat = {3'd4, 5'b10110};  // Y -.--
      6'd25: pat = {3'd4, 5'b11000};  // Z --..
      6'd26: pat = {3'd5, 5'b11111};  // 0 -----
      6'd27: pat = {3'd5, 5'b01111};  // 1 .----
      6'd28: pat = {3'd5, 5'b00111};  // 2 ..---
      6'd29: pat = {3'd5, 5'b00011};  // 3 ...--
      6'd30: pat = {3'd5, 5'b00001};  // 4 ....-
      6'd31: pat = {3'd5, 5'b00000};  // 5 .....
      6'd32: pat = {3'd5, 5'b10000};  // 6 -....
      6'd33: pat = {3'd5, 5'b11000};  // 7 --...
      6'd34: pat = {3'd5, 5'b11100};  // 8 ---..
      6'd35: pat = {3'd5, 5'b11110};  // 9 ----.
      default: pat = '0;              // word space / unused: no elements
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: buffered Morse keyer driving a single key/laser pin.
// Optional feature macro: MORSE_KEYER_SIDETONE_EN (sidetone square wave on TONE).
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   SYM        in   6-bit symbol code (0-35 characters, 36 word space, 37-63 invalid)
//   SYM_VALID  in   SYM is offered this cycle
//   SYM_READY  out  FIFO not full (from registered occupancy)
//   KEY        out  registered key drive
//   TONE       out  sidetone (0 when the sidetone feature is not built)
//   BUSY       out  FIFO non-empty or FSM not idle
//   LEVEL      out  FIFO occupancy
//   DROP       out  one-cycle pulse after an invalid code is accepted
// Handshake: a symbol transfers on every rising CLK edge where SYM_VALID and
// SYM_READY are both 1; SYM_READY never depends on SYM_VALID.
import morse_pkg::*;

module morse_keyer #(
  parameter int CLK_SPEED = 16000000,
  parameter int DIT_HZ    = 10,
  parameter int DEPTH     = 8,
  parameter int TONE_HZ   = 1000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [5:0]                 SYM,
  input  logic                       SYM_VALID,
  output logic                       SYM_READY,
  output logic                       KEY,
  output logic                       TONE,
  output logic                       BUSY,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL,
  output logic                       DROP
);

  localparam int UNIT_CYCLES = CLK_SPEED / DIT_HZ;
  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(UNIT_CYCLES - 1);
  // The word gap is bracketed by two LOAD cycles (its own and the next
  // character's), so it ends two cycles short of 4 units; the key is then low
  // for exactly 7 units between neighbouring marks.
  localparam int WG_LAST = 4 * UNIT_CYCLES - 3;
  localparam logic [1:0]    WG_UNIT = 2'(WG_LAST / UNIT_CYCLES);
  localparam logic [CW-1:0] WG_CNT  = CW'(WG_LAST % UNIT_CYCLES);

  generate
    if (UNIT_CYCLES < 2) begin : g_bad_unit
      $error("morse_keyer: CLK_SPEED/DIT_HZ must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("morse_keyer: DEPTH must be a power of two >= 2");
    end
    if (TONE_HZ < 1) begin : g_bad_tone
      $error("morse_keyer: TONE_HZ must be positive");
    end
  endgenerate

  // ---------------- FIFO ----------------
  logic [5:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          accept, push, pop;

  assign SYM_READY = (count != LW'(DEPTH));
  assign accept    = SYM_VALID && SYM_READY;
  assign push      = accept && (SYM <= SYM_MAX_VALID);
  assign LEVEL     = count;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= SYM;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      DROP   <= 1'b0;
    end else begin
      DROP <= accept && (SYM > SYM_MAX_VALID);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- Keying FSM ----------------
  state_t        state;
  logic [5:0]    sym_q;
  logic [2:0]    pat_len;    // elements still to send, including current
  logic [4:0]    pat_bits;   // current element in bit 4
  logic [CW-1:0] ucnt;
  logic [1:0]    units;      // whole units elapsed in the current state
  logic [1:0]    mult_m1;
  logic          unit_end, word_end, gap_end;
  pattern_t      rom_pat;

  morse_rom u_rom (
    .code (sym_q),
    .pat  (rom_pat)
  );

  always_comb begin
    mult_m1 = 2'd0;
    case (state)
      S_MARK:     mult_m1 = pat_bits[4] ? 2'd2 : 2'd0;
      S_CHAR_GAP: mult_m1 = 2'd2;
      default:    mult_m1 = 2'd0;
    endcase
  end

  assign unit_end = (ucnt == CNT_LAST) && (units == mult_m1);
  assign word_end = (ucnt == WG_CNT) && (units == WG_UNIT);
  assign gap_end  = ((state == S_CHAR_GAP) && unit_end) ||
                    ((state == S_WORD_GAP) && word_end);
  // A gap hands straight to the next LOAD when a symbol is waiting.
  assign pop      = (count != '0) && ((state == S_IDLE) || gap_end);
  assign BUSY     = (count != '0) || (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      KEY      <= 1'b0;
      sym_q    <= '0;
      pat_len  <= '0;
      pat_bits <= '0;
      ucnt     <= '0;
      units    <= '0;
    end else begin
      if (ucnt == CNT_LAST) begin
        ucnt  <= '0;
        units <= units + 2'd1;
      end else begin
        ucnt <= ucnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (pop) begin
            sym_q <= mem[rd_ptr];
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          ucnt  <= '0;
          units <= '0;
          if (sym_q == SYM_WORD) begin
            state <= S_WORD_GAP;
          end else begin
            pat_len  <= rom_pat.len;
            pat_bits <= rom_pat.bits;
            KEY      <= 1'b1;
            state    <= S_MARK;
          end
        end
        S_MARK: begin
          if (unit_end) begin
            ucnt     <= '0;
            units    <= '0;
            KEY      <= 1'b0;
            pat_len  <= pat_len - 3'd1;
            pat_bits <= {pat_bits[3:0], 1'b0};
            state    <= (pat_len > 3'd1) ? S_SPACE : S_CHAR_GAP;
          end
        end
        S_SPACE: begin
          if (unit_end) begin
            ucnt  <= '0;
            units <= '0;
            KEY   <= 1'b1;
            state <= S_MARK;
          end
        end
        S_CHAR_GAP, S_WORD_GAP: begin
          if (gap_end) begin
            ucnt  <= '0;
            units <= '0;
            if (pop) begin
              sym_q <= mem[rd_ptr];
              state <= S_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- Sidetone ----------------
`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int TONE_HALF = CLK_SPEED / (2 * TONE_HZ);
  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  logic [TW-1:0] tcnt;

  // Counter and output sit at 0 whenever the key is up, so every mark
  // starts with the same tone phase.
  always_ff @(posedge CLK) begin
    if (RST || !KEY) begin
      tcnt <= '0;
      TONE <= 1'b0;
    end else if (tcnt == TW'(TONE_HALF - 1)) begin
      tcnt <= '0;
      TONE <= ~TONE;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign TONE = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: directed bench for morse_keyer with CLK_SPEED=160,
// DIT_HZ=10 (16-cycle unit), DEPTH=4, TONE_HZ=20.
module tb_morse_keyer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] SYM;
  logic       SYM_VALID;
  logic       SYM_READY;
  logic       KEY;
  logic       TONE;
  logic       BUSY;
  logic [2:0] LEVEL;
  logic       DROP;

  morse_keyer #(
    .CLK_SPEED (160),
    .DIT_HZ    (10),
    .DEPTH     (4),
    .TONE_HZ   (20)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SYM       (SYM),
    .SYM_VALID (SYM_VALID),
    .SYM_READY (SYM_READY),
    .KEY       (KEY),
    .TONE      (TONE),
    .BUSY      (BUSY),
    .LEVEL     (LEVEL),
    .DROP      (DROP)
  );

  // ---------------- clock / cycle count ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];   // {key level, 15-bit run length in cycles}
  int acc_cyc;
  int first_hi;
  int tone_hi;
  int max_level;
  int ready_bad;
  bit drive_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push_run(input logic level, input int len);
    exp_q.push_back({level, 15'(len)});
  endtask

  task automatic check_run(input logic level, input int len, input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_extra_run"}, 32'(len), 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_run"}, {16'd0, level, 15'(len)}, {16'd0, e});
    end
  endtask

  // ---------------- driver ----------------
  // Offers one code until accepted; leaves SYM_VALID high for the caller.
  task automatic send(input logic [5:0] code);
    bit done;
    done = 0;
    SYM = code;
    SYM_VALID = 1'b1;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge CLK);
      if (SYM_READY) begin
        acc_cyc = cyc + 1;
        done = 1;
      end
      @(posedge CLK);
      #1;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  // ---------------- key monitor ----------------
  // Measures KEY run lengths at negedges from the first mark on and compares
  // them with exp_q; ends when driving is done and the keyer goes idle.
  task automatic watch(input int budget, input string tag);
    logic prev;
    int run;
    int tail;
    bit started;
    bit fin;
    prev = 1'b0; run = 0; tail = -1; started = 0; fin = 0;
    tone_hi = 0; first_hi = -1;
    for (int i = 0; i < budget && !fin; i++) begin
      @(negedge CLK);
      if (TONE === 1'b1) tone_hi++;
      if (int'(LEVEL) > max_level) max_level = int'(LEVEL);
      if ((LEVEL == 3'd4) == SYM_READY) ready_bad++;
      if (KEY !== prev) begin
        if (started) check_run(prev, run, tag);
        if (KEY === 1'b1 && !started) begin
          started = 1;
          first_hi = cyc;
        end
        prev = KEY;
        run = 0;
      end
      if (started && drive_done && BUSY === 1'b0 && KEY === 1'b0) begin
        fin = 1;
        tail = run;
      end else begin
        run++;
      end
    end
    check({tag, "_finished"}, 32'(fin), 1);
    check({tag, "_tail_gap"}, tail, 48);
    check({tag, "_runs_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] seq6 [6];
  bit key_seen;
  bit found;

  initial begin
    RST = 1'b1; SYM = '0; SYM_VALID = 1'b0; drive_done = 1;
    max_level = 0; ready_bad = 0;
    seq6[0] = 6'd19; seq6[1] = 6'd4;  seq6[2] = 6'd8;   // T E I
    seq6[3] = 6'd12; seq6[4] = 6'd4;  seq6[5] = 6'd19;  // M E T
    repeat (3) @(posedge CLK);
    #1;

    check("rst_key",   KEY, 0);
    check("rst_tone",  TONE, 0);
    check("rst_busy",  BUSY, 0);
    check("rst_level", LEVEL, 0);
    check("rst_drop",  DROP, 0);
    check("rst_ready", SYM_READY, 1);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // 'E': 16 high, then 48 low until idle
    send(6'd4);
    SYM_VALID = 1'b0;
    check("e_level_after_accept", LEVEL, 1);
    push_run(1'b1, 16);
    watch(400, "e");
    check("e_key_latency", first_hi, acc_cyc + 2);
`ifdef MORSE_KEYER_SIDETONE_EN
    check("e_tone_samples", tone_hi, 8);
`else
    check("e_tone_samples", tone_hi, 0);
`endif
    check("e_level_end", LEVEL, 0);

    // 'A': .-
    send(6'd0);
    SYM_VALID = 1'b0;
    push_run(1'b1, 16); push_run(1'b0, 16); push_run(1'b1, 48);
    watch(600, "a");

    // 'E', word space, 'E': 7 units of low key between the marks
    push_run(1'b1, 16); push_run(1'b0, 112); push_run(1'b1, 16);
    drive_done = 0;
    fork
      begin
        send(6'd4); send(6'd36); send(6'd4);
        SYM_VALID = 1'b0;
        drive_done = 1;
      end
      watch(800, "word");
    join

    // six codes with SYM_VALID held: T E I M E T
    push_run(1'b1, 48); push_run(1'b0, 49);                      // T
    push_run(1'b1, 16); push_run(1'b0, 49);                      // E
    push_run(1'b1, 16); push_run(1'b0, 16); push_run(1'b1, 16);  // I
    push_run(1'b0, 49);
    push_run(1'b1, 48); push_run(1'b0, 16); push_run(1'b1, 48);  // M
    push_run(1'b0, 49);
    push_run(1'b1, 16); push_run(1'b0, 49);                      // E
    push_run(1'b1, 48);                                          // T
    max_level = 0; ready_bad = 0;
    drive_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(seq6[i]);
        SYM_VALID = 1'b0;
        drive_done = 1;
      end
      watch(3000, "held6");
    join
    check("held6_max_level", max_level, 4);
    check("held6_ready_vs_full", ready_bad, 0);

    // invalid code 40
    send(6'd40);
    SYM_VALID = 1'b0;
    check("drop_pulse", DROP, 1);
    check("drop_level", LEVEL, 0);
    @(posedge CLK);
    #1;
    check("drop_clear", DROP, 0);
    check("drop_key",   KEY, 0);
    check("drop_busy",  BUSY, 0);

    // reset 20 cycles into a dah, with 'E' still queued
    send(6'd19);
    send(6'd4);
    SYM_VALID = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (KEY === 1'b1) found = 1;
    end
    check("rst_mid_found_mark", 32'(found), 1);
    repeat (19) @(negedge CLK);
    check("rst_mid_pre_key", KEY, 1);
    check("rst_mid_pre_level", LEVEL, 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_mid_key",   KEY, 0);
    check("rst_mid_level", LEVEL, 0);
    check("rst_mid_busy",  BUSY, 0);
    check("rst_mid_ready", SYM_READY, 1);
    key_seen = 0;
    repeat (150) begin
      @(negedge CLK);
      if (KEY !== 1'b0) key_seen = 1;
    end
    check("rst_mid_discarded", 32'(key_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Parametrised Morse keyer, successor to the fixed-pattern LaserMorse transmitter. Accepts a stream of 6-bit symbol codes through a valid/ready handshake and buffers them in an internal FIFO. Each symbol is encoded into standard dit/dah timing on a single KEY output, which drives the laser/LED pin. Unit length, FIFO depth and optional sidetone frequency are derived from parameters, so a board top can instantiate it once per output pin.

## Interface
- CLK_SPEED, 16000000: CLK frequency in Hz.
- DIT_HZ, 10: Morse units per second. UNIT_CYCLES = CLK_SPEED/DIT_HZ must be ≥2; otherwise elaboration fails.
- DEPTH, 8: FIFO depth in symbols. Must be a power of two, ≥2.
- TONE_HZ, 1000: sidetone frequency. Used only when MORSE_KEYER_SIDETONE_EN is defined.

Ports:
- CLK  in  1  system clock, sole clock domain.
- RST  in  1  reset, synchronous and active-high.
- SYM  in  6  symbol code: 0–25 = A–Z, 26–35 = 0–9, 36 = word space, 37–63 invalid.
- SYM_VALID  in  1  SYM is valid this cycle.
- SYM_READY  out  1  FIFO can accept a symbol. Equal to !full.
- KEY  out  1  key/laser drive, registered.
- TONE  out  1  sidetone square wave.
- BUSY  out  1  FIFO non-empty or FSM not IDLE.
- LEVEL  out  $clog2(DEPTH+1)  FIFO occupancy.
- DROP  out  1  one-cycle pulse when an invalid code is accepted.

## Operation
- Reset values: KEY=0, TONE=0, BUSY=0, LEVEL=0, DROP=0, SYM_READY=1. FIFO is emptied and FSM enters IDLE.
- Accept condition: SYM_VALID && SYM_READY.
  - Codes 0–36 are written to the FIFO.
  - Codes 37–63 are consumed but not written, and DROP pulses on the following cycle.
- FSM states: IDLE → LOAD → MARK ⇄ SPACE → CHAR_GAP → IDLE. Word-space path: IDLE → LOAD → WORD_GAP → IDLE.
  - IDLE: if FIFO is non-empty, pop one symbol and go to LOAD.
  - LOAD, one cycle: look up pattern (element count 1–5, dit/dah bits MSB-first) and register it.
  - MARK: KEY=1 for 1 unit (dit) or 3 units (dah).
  - After MARK: go to SPACE for 1 unit if elements remain; otherwise go to CHAR_GAP.
  - CHAR_GAP: KEY=0 for 3 units.
  - WORD_GAP: KEY=0 for 4 units, so the gap between neighbouring characters totals 7 units.
- A unit counter counts 0..UNIT_CYCLES−1. Its width is $clog2(UNIT_CYCLES). It reloads on every state entry, and state elapse uses a unit multiplier of 1, 3 or 4.
- Simultaneous push and pop: LEVEL stays unchanged.
  - When full, a pop in the same cycle does not open SYM_READY until the next cycle, because SYM_READY comes from the registered count.
- Pointers wrap modulo DEPTH. LEVEL distinguishes full from empty.
- Reset mid-character: KEY drops at the reset edge and the partial character is discarded.

## Timing
- Symbol accepted at edge N: LEVEL increments at N. Pop happens at N+1 (→LOAD), and KEY rises at N+2.
- With CLK_SPEED=160 and DIT_HZ=10, one unit is 16 cycles.
  - Dit: exactly 16 cycles high.
  - Dah: exactly 48 cycles high.
- Back-to-back characters: the next LOAD follows the final CHAR_GAP cycle directly, with no extra idle cycle.
- BUSY falls on the cycle the FSM returns to IDLE with the FIFO empty.

## Configuration
- MORSE_KEYER_SIDETONE_EN defined:
  - TONE toggles every CLK_SPEED/(2·TONE_HZ) cycles while KEY=1.
  - Its counter and TONE are forced to 0 on the cycle KEY is 0.
- Not defined: TONE is tied to 0, and no tone counter is synthesised.

## Structure
- Package morse_pkg holds:
  - the symbol code localparams (SYM_WORD=36, SYM_MAX_VALID=36);
  - the FSM state enum;
  - a pattern struct {len[2:0], bits[4:0]}.
- One sub-module, morse_rom: a combinational 6-bit code → pattern lookup, registered by the LOAD state.
- The FIFO is inline: a register array plus pointers.

## Test plan
All scenarios use CLK_SPEED=160, DIT_HZ=10, DEPTH=4, TONE_HZ=20.
- Push 'E' (4): KEY high for 16 cycles starting 2 cycles after accept, then 48 cycles low. BUSY then falls.
- Push 'A' (0): KEY pattern is 16 high, 16 low, 48 high, 48 low.
- Push 'E', 36, 'E': KEY low between the two marks for exactly 112 cycles.
- Hold SYM_VALID with 6 codes: SYM_READY falls once LEVEL=4. It reopens one cycle after the first pop, and all 6 characters key in order.
- Push code 40: DROP is high for one cycle, LEVEL stays 0, KEY stays 0.
- Assert RST 20 cycles into a dah: KEY=0 and LEVEL=0 at the next edge. With the macro defined, TONE toggles every 4 cycles while KEY=1.
